// File: rtl/cmd_ram_sequencer_pkg.sv
// rtl/cmd_ram_sequencer_pkg.sv - shared types and helpers for the command RAM sequencer
package cmd_ram_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_HOLD
  } seq_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Low bit of lane k in a packed vector of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/cmd_ram_sequencer_dp.sv
// rtl/cmd_ram_sequencer_dp.sv - one command bank: port A write/readback, port B read-only, both read-first
module cmd_ram_dp
  import cmd_ram_sequencer_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] a_rdata_q;
  logic [WIDTH-1:0] b_rdata_q;

  // Contents are deliberately not reset; reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata_q <= mem[a_addr];
    b_rdata_q <= mem[b_addr];
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/cmd_ram_sequencer.sv
// rtl/cmd_ram_sequencer.sv - banked command RAM with host port and looping multi-channel read sequencer
module cmd_ram_sequencer
  import cmd_ram_sequencer_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int DEPTH     = 1024,
  parameter int WIDTH     = 16,
  parameter int NUM_CH    = 3,
  parameter int SEL_W     = 4,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    host_we,
  input  logic [SEL_W-1:0]        host_bank,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [WIDTH-1:0]        host_wdata,
  output logic [WIDTH-1:0]        host_rdata,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ADDR_W-1:0]       last_index,
  input  logic [NUM_CH*SEL_W-1:0] ch_bank_sel,
  output logic [NUM_CH*WIDTH-1:0] cmd_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDR_W-1:0]       cmd_index,
  output logic                    loop_done,
  output logic                    busy
);

  seq_state_t state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       li_q, li_d;
  logic [NUM_CH*SEL_W-1:0] sel_q, sel_d;
  logic                    stop_pend_q, stop_pend_d;
  logic [NUM_CH*WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0]       cmd_index_q, cmd_index_d;
  logic                    loop_done_q, loop_done_d;
  logic [SEL_W-1:0]        hbank_q, hbank_d;
  logic                    hrd_en_q, hrd_en_d;

  logic [WIDTH-1:0]        a_rd [NUM_BANKS];
  logic [WIDTH-1:0]        b_rd [NUM_BANKS];
  logic [WIDTH-1:0]        host_word;
  logic [NUM_CH*WIDTH-1:0] ch_word;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    cmd_ram_dp #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
      .clk     (clk),
      .a_we    (host_we && (int'(host_bank) == b)),
      .a_addr  (host_addr),
      .a_wdata (host_wdata),
      .a_rdata (a_rd[b]),
      .b_addr  (addr_q),
      .b_rdata (b_rd[b])
    );
  end

  // Out-of-range bank selects match no bank and read as zero.
  always_comb begin
    host_word = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (int'(hbank_q) == b) host_word = a_rd[b];
  end

  always_comb begin
    ch_word = '0;
    for (int k = 0; k < NUM_CH; k++)
      for (int b = 0; b < NUM_BANKS; b++)
        if (int'(sel_q[lane_lo(k, SEL_W) +: SEL_W]) == b)
          ch_word[lane_lo(k, WIDTH) +: WIDTH] = b_rd[b];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    li_d        = li_q;
    sel_d       = sel_q;
    stop_pend_d = stop_pend_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    cmd_index_d = cmd_index_q;
    loop_done_d = 1'b0;
    hbank_d     = host_bank;
    hrd_en_d    = 1'b1;

    if (state_q != S_IDLE && stop) stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          li_d    = last_index;
          sel_d   = ch_bank_sel;
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        cmd_data_d  = ch_word;
        cmd_index_d = addr_q;
        cmd_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (addr_q == li_q) begin
            // Loop boundary: the only point where new length and bank selects apply.
            loop_done_d = 1'b1;
            li_d        = last_index;
            sel_d       = ch_bank_sel;
            addr_d      = '0;
            if (stop_pend_q || stop) begin
              stop_pend_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      li_q        <= '0;
      sel_q       <= '0;
      stop_pend_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= '0;
      loop_done_q <= 1'b0;
      hbank_q     <= '0;
      hrd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      li_q        <= li_d;
      sel_q       <= sel_d;
      stop_pend_q <= stop_pend_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      loop_done_q <= loop_done_d;
      hbank_q     <= hbank_d;
      hrd_en_q    <= hrd_en_d;
    end
  end

  assign host_rdata = hrd_en_q ? host_word : '0;
  assign cmd_data   = cmd_data_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;
  assign loop_done  = loop_done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
